// File: rtl/branch_resolve_unit.sv
// Branch resolution: architectural icc, PC/nPC pair, Bicc/CALL/JMPL
// evaluation and SPARC delayed control transfer with annulled delay slots.
module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv_in,
  input  logic        ex_valid_in,
  input  logic [1:0]  ex_op_in,
  input  logic [2:0]  ex_op2_in,
  input  logic [5:0]  ex_op3_in,
  input  logic [3:0]  ex_cond_in,
  input  logic        ex_a_in,
  input  logic [31:0] ex_target_in,
  input  logic        icc_we_in,
  input  logic        icc_n_in,
  input  logic        icc_z_in,
  input  logic        icc_v_in,
  input  logic        icc_c_in,
  output logic        icc_n_out,
  output logic        icc_z_out,
  output logic        icc_v_out,
  output logic        icc_c_out,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic        redirect_out,
  output logic        annul_out
);

  typedef enum logic [1:0] {
    SEQ   = 2'd0,
    DSLOT = 2'd1,
    ANNUL = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, npc_r, npc_s;
  logic        n_r, z_r, v_r, c_r;
  logic        redirect_r, annul_r;
  logic        cond_true_s, eff_s, is_bicc_s, is_call_s, is_jmpl_s;
  logic        taken_s, annul_s;

  // Bicc condition evaluated against the registered (pre-update) icc.
  always_comb begin
    cond_true_s = 1'b0;
    case (ex_cond_in)
      4'b0000: cond_true_s = 1'b0;
      4'b0001: cond_true_s = z_r;
      4'b0010: cond_true_s = z_r | (n_r ^ v_r);
      4'b0011: cond_true_s = n_r ^ v_r;
      4'b0100: cond_true_s = c_r | z_r;
      4'b0101: cond_true_s = c_r;
      4'b0110: cond_true_s = n_r;
      4'b0111: cond_true_s = v_r;
      4'b1000: cond_true_s = 1'b1;
      4'b1001: cond_true_s = ~z_r;
      4'b1010: cond_true_s = ~(z_r | (n_r ^ v_r));
      4'b1011: cond_true_s = ~(n_r ^ v_r);
      4'b1100: cond_true_s = ~(c_r | z_r);
      4'b1101: cond_true_s = ~c_r;
      4'b1110: cond_true_s = ~n_r;
      4'b1111: cond_true_s = ~v_r;
      default: cond_true_s = 1'b0;
    endcase
  end

  // Control-transfer decode, annul decision, next nPC and next FSM state.
  always_comb begin
    eff_s     = ex_valid_in & (state_r != ANNUL);
    is_bicc_s = (ex_op_in == 2'b00) & (ex_op2_in == 3'b010);
    is_call_s = (ex_op_in == 2'b01);
    is_jmpl_s = (ex_op_in == 2'b10) & (ex_op3_in == 6'b111000);
    taken_s   = eff_s & (is_call_s | is_jmpl_s | (is_bicc_s & cond_true_s));
    // BA,a and untaken Bicc,a squash the slot; taken conditional Bicc,a does not.
    annul_s   = eff_s & is_bicc_s & ex_a_in &
                (~cond_true_s | (ex_cond_in == 4'b1000));
    if (taken_s) begin
      npc_s = ex_target_in;
    end else begin
      npc_s = npc_r + PC_STEP;
    end
    state_s = SEQ;
    case (state_r)
      SEQ, DSLOT: begin
        if (annul_s) begin
          state_s = ANNUL;
        end else if (taken_s) begin
          state_s = DSLOT;
        end else begin
          state_s = SEQ;
        end
      end
      ANNUL:   state_s = SEQ;
      default: state_s = SEQ;
    endcase
  end

  // Architectural state: all registers move only on an advancing edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= SEQ;
      pc_r       <= RESET_PC;
      npc_r      <= RESET_PC + PC_STEP;
      n_r        <= 1'b0;
      z_r        <= 1'b0;
      v_r        <= 1'b0;
      c_r        <= 1'b0;
      redirect_r <= 1'b0;
      annul_r    <= 1'b0;
    end else if (adv_in) begin
      state_r    <= state_s;
      pc_r       <= npc_r;
      npc_r      <= npc_s;
      redirect_r <= taken_s;
      annul_r    <= (state_s == ANNUL);
      if (eff_s & icc_we_in) begin
        n_r <= icc_n_in;
        z_r <= icc_z_in;
        v_r <= icc_v_in;
        c_r <= icc_c_in;
      end
    end
  end

  assign pc_out       = pc_r;
  assign npc_out      = npc_r;
  assign redirect_out = redirect_r;
  assign annul_out    = annul_r;
  assign icc_n_out    = n_r;
  assign icc_z_out    = z_r;
  assign icc_v_out    = v_r;
  assign icc_c_out    = c_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, a
// behavioural PC/nPC/icc model checked every cycle, and literal pins.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adv, valid, a_bit, we;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic [3:0]  cond;
  logic [31:0] tgt;
  logic [3:0]  icc_in;  // {n,z,v,c}
  logic        n_o, z_o, v_o, c_o;
  logic [31:0] pc, npc;
  logic        redir, annul;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(rst_n), .adv_in(adv), .ex_valid_in(valid),
    .ex_op_in(op), .ex_op2_in(op2), .ex_op3_in(op3), .ex_cond_in(cond),
    .ex_a_in(a_bit), .ex_target_in(tgt), .icc_we_in(we),
    .icc_n_in(icc_in[3]), .icc_z_in(icc_in[2]), .icc_v_in(icc_in[1]), .icc_c_in(icc_in[0]),
    .icc_n_out(n_o), .icc_z_out(z_o), .icc_v_out(v_o), .icc_c_out(c_o),
    .pc_out(pc), .npc_out(npc), .redirect_out(redir), .annul_out(annul)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_npc;
  logic [3:0]  m_icc;
  logic        m_redir, m_annul;  // m_annul: next instruction is squashed

  // Base conditions indexed by cond[2:0]; cond[3] complements (BN->BA etc.).
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic [7:0] b;
    b = {f[1], f[3], f[0], f[0] | f[2], f[3] ^ f[1], f[2] | (f[3] ^ f[1]), f[2], 1'b0};
    return b[c[2:0]] ^ c[3];
  endfunction

  wire m_eff  = valid & ~m_annul;
  wire m_ct   = cond_eval(cond, m_icc);
  wire m_bicc = (op == 2'b00) && (op2 == 3'b010);
  wire m_tk   = m_eff & ((op == 2'b01) | ((op == 2'b10) && (op3 == 6'b111000)) | (m_bicc & m_ct));
  wire m_an   = m_eff & m_bicc & a_bit & (~m_ct | (cond == 4'b1000));

  // Model state update on each advancing edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_npc <= 32'h4; m_icc <= 4'h0; m_redir <= 1'b0; m_annul <= 1'b0;
    end else if (adv) begin
      m_pc    <= m_npc;
      m_npc   <= m_tk ? tgt : m_npc + 32'd4;
      m_redir <= m_tk;
      m_annul <= m_an;
      if (m_eff && we) m_icc <= icc_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc.pc", pc, m_pc);
      chk("cyc.npc", npc, m_npc);
      chk("cyc.icc", {28'd0, n_o, z_o, v_o, c_o}, {28'd0, m_icc});
      chk("cyc.redirect", {31'd0, redir}, {31'd0, m_redir});
      chk("cyc.annul", {31'd0, annul}, {31'd0, m_annul});
    end
  end

  // Hand-computed expectations applied to both DUT and model.
  task automatic pin(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                     input logic e_rd, input logic e_an, input logic [3:0] e_icc);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".npc"}, npc, e_npc);
    chk({tag, ".redirect"}, {31'd0, redir}, {31'd0, e_rd});
    chk({tag, ".annul"}, {31'd0, annul}, {31'd0, e_an});
    chk({tag, ".icc"}, {28'd0, n_o, z_o, v_o, c_o}, {28'd0, e_icc});
    chk({tag, ".model_pc"}, m_pc, e_pc);
    chk({tag, ".model_npc"}, m_npc, e_npc);
  endtask

  task automatic drive(input logic a_v, input logic v_v, input logic [1:0] op_v,
                       input logic [2:0] op2_v, input logic [5:0] op3_v, input logic [3:0] c_v,
                       input logic an_v, input logic [31:0] t_v, input logic we_v,
                       input logic [3:0] icc_v);
    adv = a_v; valid = v_v; op = op_v; op2 = op2_v; op3 = op3_v; cond = c_v;
    a_bit = an_v; tgt = t_v; we = we_v; icc_in = icc_v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'b10, 3'b000, 6'b000000, 4'h0, 1'b0, 32'h0, 1'b0, 4'h0);
  endtask
  task automatic alu(input logic w, input logic [3:0] f);
    drive(1'b1, 1'b1, 2'b10, 3'b000, 6'b010100, 4'h0, 1'b0, 32'h0, w, f);
  endtask
  task automatic bicc(input logic [3:0] c, input logic an, input logic [31:0] t);
    drive(1'b1, 1'b1, 2'b00, 3'b010, 6'b000000, c, an, t, 1'b0, 4'h0);
  endtask
  task automatic call(input logic [31:0] t);
    drive(1'b1, 1'b1, 2'b01, 3'b000, 6'b000000, 4'h0, 1'b0, t, 1'b0, 4'h0);
  endtask
  task automatic jmpl(input logic [31:0] t);
    drive(1'b1, 1'b1, 2'b10, 3'b000, 6'b111000, 4'h0, 1'b0, t, 1'b0, 4'h0);
  endtask

  logic [3:0] pats [7] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b1010, 4'b0101};

  initial begin
    rst_n = 1'b0;
    adv = 1'b1; valid = 1'b0; op = 2'b10; op2 = 3'b000; op3 = 6'b000000;
    cond = 4'h0; a_bit = 1'b0; tgt = 32'h0; we = 1'b0; icc_in = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    pin("reset", 32'h0, 32'h4, 1'b0, 1'b0, 4'h0);
    cmp_en = 1'b1;

    idle(); idle(); idle();
    pin("seq3", 32'hC, 32'h10, 1'b0, 1'b0, 4'h0);
    alu(1'b1, 4'b0100);                       // z=1
    bicc(4'b0001, 1'b0, 32'h100);             // BE taken
    pin("be_taken", 32'h14, 32'h100, 1'b1, 1'b0, 4'b0100);
    alu(1'b0, 4'h0);                          // delay slot
    pin("be_target", 32'h100, 32'h104, 1'b0, 1'b0, 4'b0100);
    alu(1'b1, 4'b0000);                       // icc cleared
    bicc(4'b0001, 1'b1, 32'h200);             // BE,a untaken
    pin("be_a_untaken", 32'h108, 32'h10C, 1'b0, 1'b1, 4'h0);
    alu(1'b1, 4'b1111);                       // squashed: icc must stay
    pin("squashed", 32'h10C, 32'h110, 1'b0, 1'b0, 4'h0);
    bicc(4'b1000, 1'b1, 32'h300);             // BA,a
    pin("ba_a", 32'h110, 32'h300, 1'b1, 1'b1, 4'h0);
    call(32'h999);                            // squashed CALL in slot
    pin("ba_target", 32'h300, 32'h304, 1'b0, 1'b0, 4'h0);
    bicc(4'b0000, 1'b0, 32'h700);             // BN
    pin("bn", 32'h304, 32'h308, 1'b0, 1'b0, 4'h0);
    bicc(4'b0000, 1'b1, 32'h700);             // BN,a annuls
    pin("bn_a", 32'h308, 32'h30C, 1'b0, 1'b1, 4'h0);
    idle();
    drive(1'b0, 1'b1, 2'b10, 3'b000, 6'b010100, 4'h0, 1'b0, 32'h0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 2'b10, 3'b000, 6'b010100, 4'h0, 1'b0, 32'h0, 1'b1, 4'b1000);
    pin("stall", 32'h30C, 32'h310, 1'b0, 1'b0, 4'h0);
    alu(1'b1, 4'b1000);                       // SUBcc advances
    pin("subcc", 32'h310, 32'h314, 1'b0, 1'b0, 4'b1000);
    bicc(4'b0011, 1'b0, 32'h600);             // BL taken (n^v)
    pin("bl", 32'h314, 32'h600, 1'b1, 1'b0, 4'b1000);
    alu(1'b0, 4'h0);
    call(32'h400);
    pin("call", 32'h604, 32'h400, 1'b1, 1'b0, 4'b1000);
    jmpl(32'h500);                            // DCTI couple
    pin("jmpl_slot", 32'h400, 32'h500, 1'b1, 1'b0, 4'b1000);
    idle();
    pin("jmpl_target", 32'h500, 32'h504, 1'b0, 1'b0, 4'b1000);
    call(32'h800);
    bicc(4'b0001, 1'b1, 32'h900);             // untaken BE,a -> ANNUL
    pin("pre_reset", 32'h800, 32'h804, 1'b0, 1'b1, 4'b1000);
    #2 rst_n = 1'b0;
    #1 pin("async_reset", 32'h0, 32'h4, 1'b0, 1'b0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    jmpl(32'hFFFF_FFFC);
    idle();
    pin("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 4'h0);
    idle();
    pin("wrap2", 32'h0, 32'h4, 1'b0, 1'b0, 4'h0);

    // Every condition code under several icc patterns, model-checked.
    for (int p = 0; p < 7; p++) begin
      alu(1'b1, pats[p]);
      for (int c = 0; c < 16; c++) begin
        bicc(4'(c), 1'((c + p) % 3 == 0), 32'h1000 + 32'(c * 16));
        idle();
      end
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sequential consumer of the ALU's branch/condition-code outputs: holds the architectural icc (n,z,v,c) register and the PC/nPC pair.
- Evaluates the 16 Bicc conditions and implements SPARC delayed control transfer with annul.
- Sits between EX and fetch.
- Drives the registered next-fetch PC, a redirect strobe and a delay-slot annul flag back to fetch/decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- adv_in  in  1  pipeline advance; 0 = stall, all state holds.
- ex_valid_in  in  1  EX holds a valid instruction.
- ex_op_in  in  2  instruction op field.
- ex_op2_in  in  3  op2 field (010 = Bicc).
- ex_op3_in  in  6  op3 field (111000 = JMPL).
- ex_cond_in  in  4  Bicc cond field.
- ex_a_in  in  1  annul bit.
- ex_target_in  in  32  target address computed by the ALU.
- icc_we_in  in  1  EX instruction is a cc-setting op.
- icc_n_in, icc_z_in, icc_v_in, icc_c_in  in  1 each  new icc from the ALU.
- icc_n_out, icc_z_out, icc_v_out, icc_c_out  out  1 each  registered icc (PSR.icc).
- pc_out  out  32  PC of the instruction being fetched.
- npc_out  out  32  nPC register.
- redirect_out  out  1  npc_out was loaded from a target on the last advance.
- annul_out  out  1  instruction at pc_out must be squashed.

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, npc=RESET_PC+4, icc=0000, redirect_out=0, annul_out=0, FSM=SEQ.
- All updates occur only on a rising clk with adv_in=1. With adv_in=0, every register and output holds.
- Effective instruction: eff = ex_valid_in & (FSM != ANNUL). A squashed instruction never updates icc or redirects.
- Condition evaluation always uses the registered icc (pre-update value), never icc_*_in. Conditions by ex_cond_in:
  - 0000 BN = 0
  - 0001 BE = z
  - 0010 BLE = z|(n^v)
  - 0011 BL = n^v
  - 0100 BLEU = c|z
  - 0101 BCS = c
  - 0110 BNEG = n
  - 0111 BVS = v
  - 1000 BA = 1
  - 1001–1111 = complements of 0001–0111 (BNE, BG, BGE, BGU, BCC, BPOS, BVC).
- taken = eff & (op==01 CALL | (op==10 & op3==111000) JMPL | (op==00 & op2==010 & cond_true)).
- Advance step: pc<=npc; npc<=taken ? ex_target_in : npc+PC_STEP (32-bit wrap, no overflow flag); redirect_out<=taken.
- icc update: if eff & icc_we_in, icc<=icc_*_in, same edge.
- Annul condition: annul = eff & Bicc & ex_a_in & (~cond_true | cond==1000). BA,a annuls its delay slot. Untaken Bicc,a annuls. Taken conditional Bicc,a does not annul. CALL/JMPL never annul.
- FSM states:
  - SEQ: no CTI outstanding. On advance, go to DSLOT if taken & ~annul; ANNUL if annul; else stay SEQ.
  - DSLOT: delay-slot instruction executing. Evaluated like SEQ, so a DCTI couple follows SPARC semantics (the second target lands in npc).
  - ANNUL: annul_out=1. The instruction is ignored; on advance go to SEQ with npc<=npc+PC_STEP.
- annul_out = (FSM==ANNUL); a registered state decode, valid one cycle after the annulling branch.
- Asserting reset mid-sequence (any state) returns to the reset values immediately; no pending redirect survives.

Test Plan:
- Reset release, adv_in=1, no valid instructions, 3 edges -> pc = 0,4,8,C; redirect_out=0; annul_out=0.
- icc=z=1, BE (cond 0001, a=0), target 0x100, pc=0x10 -> next edge npc=0x100, redirect_out=1; following edge pc=0x100, FSM SEQ.
- icc=0000, BE a=1, target 0x200 -> not taken, annul_out=1 for the next instruction. That instruction carries icc_we_in=1 with icc_in=1111, yet icc stays 0000; npc continues sequentially.
- BA a=1, target 0x300 -> annul_out=1 for the delay slot, then pc=0x300. BN a=0 -> no redirect, no annul.
- SUBcc with icc_we_in=1, icc_in n=1,v=0 and adv_in=0 for 2 cycles -> icc unchanged. With adv_in=1 -> icc=1000. Next BL (0011) is taken.
- Taken CALL (op=01, target 0x400), then JMPL in the delay slot (target 0x500) -> pc sequence: slot, 0x400, 0x500. Assert reset mid-sequence -> pc=RESET_PC asynchronously.
